// File: rtl/ram_wr_queue_pkg.sv
// Shared types and sizing for the RAM write queue and its read-forwarding logic.
package ram_wr_queue_pkg;

   localparam int DEPTH        = 16;
   localparam int INDEX        = $clog2(DEPTH);
   localparam int WIDTH        = 8;
   localparam int QDEPTH       = 8;
   localparam int QINDEX       = $clog2(QDEPTH);
   localparam int CNT_W        = QINDEX + 1;
   localparam int READY_THRESH = 2;
   localparam int NUM_RD       = 4;

   typedef logic [QINDEX-1:0] qptr_t;
   typedef logic [CNT_W-1:0]  cnt_t;

   typedef struct packed {
      logic [INDEX-1:0] addr;
      logic [WIDTH-1:0] data;
   } entry_t;

   // Queue pointer plus an offset, wrapping modulo QDEPTH.
   function automatic qptr_t ptr_add(input qptr_t ptr, input cnt_t offset);
      return ptr + qptr_t'(offset);
   endfunction

endpackage

// File: rtl/ram_wr_queue_if.sv
// Bus bundle between the upstream write/read clients, the write queue and the RAM.
interface ram_wr_queue_if;
   import ram_wr_queue_pkg::*;

   logic                          wr0_valid;
   logic [INDEX-1:0]              wr0_addr;
   logic [WIDTH-1:0]              wr0_data;
   logic                          wr1_valid;
   logic [INDEX-1:0]              wr1_addr;
   logic [WIDTH-1:0]              wr1_data;
   logic                          wr_ready;
   logic                          ram_we;
   logic [INDEX-1:0]              ram_waddr;
   logic [WIDTH-1:0]              ram_wdata;
   logic [NUM_RD-1:0][INDEX-1:0]  rd_addr;
   logic [NUM_RD-1:0][WIDTH-1:0]  ram_rdata;
   logic [NUM_RD-1:0][WIDTH-1:0]  rd_data;
   logic                          busy;

   modport master (
      output wr0_valid, wr0_addr, wr0_data,
      output wr1_valid, wr1_addr, wr1_data,
      output rd_addr, ram_rdata,
      input  wr_ready, ram_we, ram_waddr, ram_wdata, rd_data, busy
   );

   modport slave (
      input  wr0_valid, wr0_addr, wr0_data,
      input  wr1_valid, wr1_addr, wr1_data,
      input  rd_addr, ram_rdata,
      output wr_ready, ram_we, ram_waddr, ram_wdata, rd_data, busy
   );

endinterface

// File: rtl/ram_wr_fwd_match.sv
// One read port's forwarding search: newest queued write to the read address wins,
// otherwise the raw RAM data passes through.
module ram_wr_fwd_match
   import ram_wr_queue_pkg::*;
(
   input  entry_t           entries [QDEPTH],
   input  qptr_t            head,
   input  cnt_t             count,
   input  logic [INDEX-1:0] rd_addr,
   input  logic [WIDTH-1:0] ram_rdata,
   output logic [WIDTH-1:0] rd_data
);

   // Walk valid entries oldest to youngest so the last hit, the youngest, is kept.
   always_comb begin
      qptr_t idx;
      rd_data = ram_rdata;
      idx     = '0;
      for (int i = 0; i < QDEPTH; i++) begin
         idx = ptr_add(head, cnt_t'(i));
         if ((cnt_t'(i) < count) && (entries[idx].addr == rd_addr)) begin
            rd_data = entries[idx].data;
         end
      end
   end

endmodule

// File: rtl/ram_wr_queue.sv
// Write-side front end of the 1W/4R register RAM: in-order queue taking up to two
// writes per cycle, draining one per cycle, with forwarding of pending data to readers.
module ram_wr_queue
   import ram_wr_queue_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   ram_wr_queue_if.slave bus
);

   entry_t                       entries [QDEPTH];
   qptr_t                        head;
   qptr_t                        tail;
   cnt_t                         count;
   logic                         ready;
   logic                         accept0;
   logic                         accept1;
   logic                         deq;
   logic [1:0]                   n_accept;
   qptr_t                        slot1;
   logic [NUM_RD-1:0][WIDTH-1:0] fwd_data;

   // Acceptance is all-or-nothing, gated on room for a full pair; wr1 lands after wr0.
   always_comb begin
      ready    = (count <= cnt_t'(QDEPTH - READY_THRESH));
      accept0  = ready && bus.wr0_valid;
      accept1  = ready && bus.wr1_valid;
      n_accept = {1'b0, accept0} + {1'b0, accept1};
      slot1    = accept0 ? ptr_add(tail, cnt_t'(1)) : tail;
      deq      = (count != '0);
   end

   // Pointer and occupancy bookkeeping; reset discards everything still pending.
   always_ff @(posedge clk) begin
      if (!reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= ptr_add(head, cnt_t'(deq));
         tail  <= ptr_add(tail, cnt_t'(n_accept));
         count <= count + cnt_t'(n_accept) - cnt_t'(deq);
      end
   end

   // Entry storage needs no reset: only slots inside [head, head+count) are ever looked at.
   always_ff @(posedge clk) begin
      if (reset && accept0) begin
         entries[tail] <= '{addr: bus.wr0_addr, data: bus.wr0_data};
      end
      if (reset && accept1) begin
         entries[slot1] <= '{addr: bus.wr1_addr, data: bus.wr1_data};
      end
   end

   // Head entry drives the RAM write port; the write is suppressed in a reset cycle so
   // that a reset mid-drain leaves none of the discarded entries in the RAM.
   always_comb begin
      bus.wr_ready  = ready;
      bus.busy      = deq;
      bus.ram_we    = deq && reset;
      bus.ram_waddr = '0;
      bus.ram_wdata = '0;
      if (deq) begin
         bus.ram_waddr = entries[head].addr;
         bus.ram_wdata = entries[head].data;
      end
      bus.rd_data = fwd_data;
   end

   for (genvar k = 0; k < NUM_RD; k++) begin : g_fwd
      ram_wr_fwd_match u_fwd (
         .entries   (entries),
         .head      (head),
         .count     (count),
         .rd_addr   (bus.rd_addr[k]),
         .ram_rdata (bus.ram_rdata[k]),
         .rd_data   (fwd_data[k])
      );
   end

endmodule

// File: tb/tb_ram_wr_queue.sv
// Self-checking bench for ram_wr_queue: directed scenarios plus randomized traffic,
// checked every cycle against a queue-based reference model and a model of the RAM.
module tb_ram_wr_queue;
   import ram_wr_queue_pkg::*;

   logic clk;
   logic reset;

   ram_wr_queue_if bus ();

   ram_wr_queue dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [WIDTH-1:0] tb_ram    [DEPTH];
   logic [WIDTH-1:0] model_ram [DEPTH];
   entry_t           mq [$];
   bit               model_known;
   bit               last_acc;
   int               total;
   int               bad;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // The RAM itself: captures the write port at the edge, reads asynchronously.
   always @(posedge clk) begin
      if (bus.ram_we) tb_ram[bus.ram_waddr] <= bus.ram_wdata;
   end

   always_comb begin
      for (int k = 0; k < NUM_RD; k++) bus.ram_rdata[k] = tb_ram[bus.rd_addr[k]];
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected outputs from the model queue: oldest at index 0, youngest at the back.
   task automatic checkCycle();
      logic [WIDTH-1:0] exp_rd;
      logic [INDEX-1:0] a;
      if (!model_known) return;
      checkOutput("busy", 32'(bus.busy), 32'(mq.size() != 0));
      checkOutput("we", 32'(bus.ram_we), 32'((mq.size() != 0) && reset));
      checkOutput("ready", 32'(bus.wr_ready), 32'((QDEPTH - mq.size()) >= 2));
      checkOutput("waddr", 32'(bus.ram_waddr), (mq.size() != 0) ? 32'(mq[0].addr) : 32'd0);
      checkOutput("wdata", 32'(bus.ram_wdata), (mq.size() != 0) ? 32'(mq[0].data) : 32'd0);
      for (int k = 0; k < NUM_RD; k++) begin
         a      = bus.rd_addr[k];
         exp_rd = model_ram[a];
         foreach (mq[j]) if (mq[j].addr == a) exp_rd = mq[j].data;
         checkOutput($sformatf("rd%0d", k), 32'(bus.rd_data[k]), 32'(exp_rd));
      end
   endtask

   // Advance the model by one clock edge using the inputs that were sampled there.
   task automatic updateModel();
      bit acc;
      if (!reset) begin
         mq.delete();
         model_known = 1'b1;
         last_acc    = 1'b0;
      end else begin
         acc = ((QDEPTH - mq.size()) >= 2);
         if (mq.size() != 0) begin
            model_ram[mq[0].addr] = mq[0].data;
            void'(mq.pop_front());
         end
         if (acc && bus.wr0_valid) mq.push_back('{addr: bus.wr0_addr, data: bus.wr0_data});
         if (acc && bus.wr1_valid) mq.push_back('{addr: bus.wr1_addr, data: bus.wr1_data});
         last_acc = acc;
      end
   endtask

   function automatic logic [INDEX-1:0] pickAddr();
      if (mq.size() != 0 && $urandom_range(0, 1) == 1)
         return mq[$urandom_range(0, mq.size() - 1)].addr;
      return INDEX'($urandom_range(0, DEPTH - 1));
   endfunction

   // Drive one cycle of inputs (just after a falling edge), check, then step the model.
   task automatic applyStimulus(input logic rst,
                                input logic v0, input logic [INDEX-1:0] a0, input logic [WIDTH-1:0] d0,
                                input logic v1, input logic [INDEX-1:0] a1, input logic [WIDTH-1:0] d1,
                                input logic [NUM_RD-1:0][INDEX-1:0] ra);
      reset         = rst;
      bus.wr0_valid = v0;
      bus.wr0_addr  = a0;
      bus.wr0_data  = d0;
      bus.wr1_valid = v1;
      bus.wr1_addr  = a1;
      bus.wr1_data  = d1;
      bus.rd_addr   = ra;
      #1;
      checkCycle();
      @(posedge clk);
      updateModel();
      @(negedge clk);
   endtask

   task automatic idleCycle(input logic [NUM_RD-1:0][INDEX-1:0] ra);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, ra);
   endtask

   task automatic drainAll();
      int guard;
      guard = 0;
      while (mq.size() != 0 && guard < 20) begin
         idleCycle({pickAddr(), pickAddr(), pickAddr(), pickAddr()});
         guard++;
      end
      checkOutput("drain_timeout", 32'(mq.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int k;
      int guard;
      logic [INDEX-1:0] a;
      total       = 0;
      bad         = 0;
      model_known = 1'b0;
      last_acc    = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         tb_ram[i]    = WIDTH'(8'hC0 + i);
         model_ram[i] = WIDTH'(8'hC0 + i);
      end

      // Reset held two cycles while a write is presented; it must be dropped.
      applyStimulus(1'b0, 1'b1, 4'd3, 8'hAA, 1'b0, '0, '0, '{default: '0});
      applyStimulus(1'b0, 1'b1, 4'd3, 8'hAA, 1'b0, '0, '0, '{default: '0});
      idleCycle({4'd3, 4'd3, 4'd3, 4'd3});
      checkOutput("ram3_after_reset", 32'(tb_ram[3]), 32'h000000C3);

      // Single write then forwarded read before and after it reaches the RAM.
      applyStimulus(1'b1, 1'b1, 4'd5, 8'h11, 1'b0, '0, '0, {4'd0, 4'd0, 4'd0, 4'd5});
      idleCycle({4'd0, 4'd0, 4'd0, 4'd5});
      checkOutput("ram5_written", 32'(tb_ram[5]), 32'h00000011);
      idleCycle({4'd5, 4'd5, 4'd5, 4'd5});

      // Same address in both slots: the younger slot must win.
      applyStimulus(1'b1, 1'b1, 4'd7, 8'h01, 1'b1, 4'd7, 8'h02, {4'd7, 4'd7, 4'd7, 4'd7});
      idleCycle({4'd7, 4'd7, 4'd7, 4'd7});
      idleCycle({4'd7, 4'd7, 4'd7, 4'd7});
      checkOutput("ram7_final", 32'(tb_ram[7]), 32'h00000002);

      // Fill: both ports every cycle, each pair held until the queue accepts it.
      k     = 0;
      guard = 0;
      while (k < DEPTH && guard < 100) begin
         applyStimulus(1'b1, 1'b1, INDEX'(k), WIDTH'(k + 8'h40),
                       1'b1, INDEX'(k + 1), WIDTH'(k + 1 + 8'h40),
                       {pickAddr(), pickAddr(), pickAddr(), pickAddr()});
         if (last_acc) k += 2;
         guard++;
      end
      checkOutput("fill_timeout", 32'(k), 32'(DEPTH));
      drainAll();

      // Pointer wrap with single writes to a few addresses, alternating the slot used.
      for (int i = 0; i < 20; i++) begin
         a = INDEX'($urandom_range(0, 3));
         if (i % 2 == 0)
            applyStimulus(1'b1, 1'b1, a, WIDTH'($urandom), 1'b0, '0, '0,
                          {pickAddr(), pickAddr(), a, pickAddr()});
         else
            applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, a, WIDTH'($urandom),
                          {pickAddr(), a, pickAddr(), pickAddr()});
      end
      drainAll();

      // Build up six pending entries, then reset: none of them may reach the RAM.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b1, INDEX'(8 + i), WIDTH'(8'hE0 + i),
                       1'b1, INDEX'(8 + i), WIDTH'(8'hF0 + i),
                       {pickAddr(), pickAddr(), pickAddr(), pickAddr()});
      end
      checkOutput("pending_before_reset", 32'(mq.size()), 32'd6);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, {4'd8, 4'd9, 4'd10, 4'd12});
      idleCycle({4'd8, 4'd9, 4'd10, 4'd12});
      idleCycle({4'd11, 4'd12, 4'd13, 4'd14});

      // Randomized traffic with occasional resets and a small address range for hits.
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 49) != 0),
                       1'($urandom), INDEX'($urandom_range(0, 7)), WIDTH'($urandom),
                       1'($urandom), INDEX'($urandom_range(0, 7)), WIDTH'($urandom),
                       {pickAddr(), pickAddr(), pickAddr(), pickAddr()});
      end
      drainAll();
      idleCycle('{default: '0});

      for (int i = 0; i < DEPTH; i++) begin
         checkOutput($sformatf("ram_final%0d", i), 32'(tb_ram[i]), 32'(model_ram[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ram_wr_queue.md
Name: ram_wr_queue

Overview:
- Write-side front end for the single-write-port, 4-read-port register RAM.
- Accepts up to two write requests per cycle into an in-order queue and drains exactly one per cycle into the RAM's single write port.
- Forwards pending (queued, not yet written) data to the four read ports, so readers always see the newest value for an address.
- Sits directly upstream of the RAM. Drives its write port, and post-muxes its four read data outputs.

Parameters:
- DEPTH, 16: RAM entries.
- INDEX, 4: RAM address width, log2(DEPTH).
- WIDTH, 8: data width.
- QDEPTH, 8: queue entries; power of two, at least 2.
- QINDEX, 3: log2(QDEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled at posedge clk).
- wr0_valid_i  in  1  write request 0 valid (older of the pair).
- wr0_addr_i  in  INDEX  write request 0 address.
- wr0_data_i  in  WIDTH  write request 0 data.
- wr1_valid_i  in  1  write request 1 valid (younger of the pair).
- wr1_addr_i  in  INDEX  write request 1 address.
- wr1_data_i  in  WIDTH  write request 1 data.
- wr_ready_o  out  1  queue can accept two entries this cycle.
- ram_we_o  out  1  RAM write enable.
- ram_waddr_o  out  INDEX  RAM write address.
- ram_wdata_o  out  WIDTH  RAM write data.
- rd_addr0_i..rd_addr3_i  in  INDEX each  read addresses; the same addresses also drive the RAM.
- ram_rdata0_i..ram_rdata3_i  in  WIDTH each  raw RAM read data.
- rd_data0_o..rd_data3_o  out  WIDTH each  forwarded read data.
- busy_o  out  1  queue non-empty.

Behaviour:
- State: QDEPTH entries of {addr, data}; head pointer and tail pointer (QINDEX bits, wrap modulo QDEPTH); count (QINDEX+1 bits).
- Reset (reset==0 at posedge): head=tail=count=0; all pending entries discarded, including a reset mid-drain.
- After reset: ram_we_o=0, busy_o=0, wr_ready_o=1, ram_waddr_o=0, ram_wdata_o=0. rd_dataK_o equals ram_rdataK_i.
- wr_ready_o = (QDEPTH - count >= 2), combinational from registered count. Acceptance is all-or-nothing per cycle.
- Enqueue happens only when wr_ready_o=1:
  - wr0 is written at tail, then wr1 at tail+1.
  - If only wr1 is valid, it is written at tail.
  - Accepted count n = wr0_valid_i + wr1_valid_i, i.e. 0..2.
- Requests presented while wr_ready_o=0 are ignored. Upstream must hold them until ready.
- Drain:
  - ram_we_o = (count != 0); ram_waddr_o and ram_wdata_o are the head entry, combinational from the registers.
  - When count != 0, head advances by 1 at every posedge. The RAM captures the same entry at that same edge, so there is no visibility gap.
  - When empty, ram_waddr_o and ram_wdata_o hold 0.
- Count update: count_next = count + n - (count != 0). Simultaneous enqueue and dequeue is legal. At full (count=QDEPTH) the queue drains one entry per cycle and wr_ready_o goes high once count reaches QDEPTH-2 or less.
- Enqueue latency: an entry accepted at edge T is at the head no earlier than T. If the queue was empty it is written to the RAM at edge T+1.
- Forwarding, per read port K, combinational:
  - Scan valid entries youngest to oldest; the first with addr == rd_addrK_i supplies rd_dataK_o.
  - If there is no match, rd_dataK_o = ram_rdataK_i.
  - The head entry counts as a valid entry.
  - Same-cycle incoming wr0/wr1 requests are NOT forwarded; they become visible the cycle after acceptance.
- Same address in wr0 and wr1 in one cycle: both are queued, and wr1 wins both in the RAM and in forwarding.
- Valid-entry test: an entry at offset i from head (0 <= i < count) is valid; computed with wrap-around pointer arithmetic.

Decomposition:
- Shared package holds:
  - typedef for the entry struct {addr[INDEX-1:0], data[WIDTH-1:0]};
  - localparam for the ready threshold (2);
  - count width = QINDEX+1.
- One sub-module, ram_wr_fwd_match: one read port's youngest-match search over the queue (inputs: entries, head, count, rd_addr, ram_rdata; output: rd_data). It is instantiated four times.

Test Plan:
- Reset held (reset=0) for 2 cycles with wr0 valid (addr 3, data 0xAA) -> busy_o=0, ram_we_o=0, wr_ready_o=1 after release; RAM[3] unchanged.
- Single write: wr0 addr 5, data 0x11 at cycle 1 -> cycle 2 ram_we_o=1, ram_waddr_o=5, ram_wdata_o=0x11; rd_addr0=5 reads 0x11 in cycle 2; RAM holds 0x11 at cycle 3; busy_o=0 at cycle 3.
- Same-address pair: wr0 (7, 0x01) and wr1 (7, 0x02) in one cycle -> forwarded read of 7 returns 0x02 the next cycle. RAM writes 0x01, then 0x02; final RAM[7]=0x02.
- Fill: present both write ports every cycle (addrs 0..15, data = addr+0x40) -> wr_ready_o drops when count would exceed QDEPTH-2. Every request ready-accepted is written to the RAM in order, one per cycle; none lost or duplicated.
- Wrap-around: 20 sequential single writes with interleaved reads of every pending address -> reads always return the youngest value; pointers wrap past QDEPTH with no stale forwarding.
- Reset mid-operation: count=6, assert reset for one cycle -> next cycle busy_o=0, ram_we_o=0; the pending 6 entries are never written to the RAM.
